ws2812_input_decoder: RTL
=========================

# ws2812_input_decoder

Receiving end of the WS2812 single-wire LED protocol produced by `ws2812_output_shifter`. It samples the serial line, classifies each high pulse as a 0 or 1 bit by its width, and assembles bits MSB-first into bytes. It signals the end of each frame on the protocol's reset gap. The block sits beside the fader/shifter chain as a loopback checker on the transmit pin, and can also serve as a front end for daisy-chained board inputs.

## Interface
- `THRESHOLD`, 7: high-pulse length in clk cycles at or above which a bit decodes as 1; below it, the bit is 0. The default suits 12 MHz, where T0H is about 5 cycles and T1H about 10.
- `MAX_HIGH`, 24: a high pulse longer than this many cycles is a protocol error.
- `RESET_CYCLES`, 600: low time in cycles that constitutes the reset/latch gap (50 us at 12 MHz). Legal range is 2..65534.
- `clk` input 1: sole clock.
- `rst` input 1: reset, asynchronous, active-low.
- `din` input 1: WS2812 serial line, asynchronous to `clk`.
- `data` output 8: last completed byte. Holds between updates.
- `data_valid` output 1: one-cycle pulse when `data` is updated.
- `byte_index` output 8: index within the current frame of the byte on `data`. The first byte is 0; saturates at 255.
- `frame_end` output 1: one-cycle pulse when a reset gap terminates a frame.
- `error` output 1: one-cycle pulse on a protocol violation.
- `busy` output 1: high while the state is HIGH or LOW, i.e. inside a frame.

## Operation
- **Input synchronizer.** `din` passes through two flops, `s1` then `s2`. A third flop `s3` holds the previous `s2`.
  - Rise: `s2`=1 and `s3`=0.
  - Fall: `s2`=0 and `s3`=1.
- **Counters.** 16-bit `cnt` is shared by all states and saturates at 0xFFFF. A 3-bit `bit_cnt` counts bits; an 8-bit shift register `sh` accumulates them.
- **States.**
  - **SYNC** (reset state). Each cycle with `s2`=1 clears `cnt`; each cycle with `s2`=0 increments it. When `cnt` reaches `RESET_CYCLES`, go to IDLE. No pulses are issued. This guarantees the decoder never locks on mid-frame.
  - **IDLE.** On rise, go to HIGH with `cnt`=1, `bit_cnt`=0, and the frame byte counter at 0.
  - **HIGH.** Increment `cnt` each cycle while `s2`=1.
    - If `cnt` exceeds `MAX_HIGH`: pulse `error`, discard the partial byte, and go to SYNC with `cnt`=0.
    - On fall: shift in bit = (`cnt` >= `THRESHOLD`) at the LSB of `sh`, increment `bit_cnt`, load `cnt`=1, and go to LOW.
    - When the 8th bit is shifted in: register `data` = {`sh`[6:0], bit}, pulse `data_valid`, and set `byte_index` = frame byte counter. The counter then increments and saturates at 255.
  - **LOW.**
    - On rise: `cnt`=1, go to HIGH.
    - Otherwise increment `cnt`. When `cnt` reaches `RESET_CYCLES`: pulse `frame_end` and go to IDLE.
    - If `bit_cnt` is not 0 at that point, also pulse `error` in the same cycle and discard the partial bits.
- **Simultaneous events.**
  - The HIGH overflow check applies before fall detection in the same cycle.
  - `data_valid` and `frame_end` can never coincide, because `frame_end` requires at least `RESET_CYCLES` cycles of LOW.
- **Reset.** Reset asserted at any time, including mid-byte, returns to SYNC immediately and clears all state.

## Timing
- Reset values:
  - Outputs: `data`=0x00, `data_valid`=0, `byte_index`=0, `frame_end`=0, `error`=0, `busy`=0.
  - Internal: `sh`=0, `bit_cnt`=0, `cnt`=0, `s1`/`s2`/`s3`=0.
- All outputs are registered.
- Latency for `data_valid`: the clock edge that first samples `din`=0 after the 8th bit's high pulse is edge k. `data_valid` is high during the cycle after edge k+2, for exactly one cycle.
- Measured high width is the number of edges that sampled `din`=1, with ±1 cycle quantisation.
- Latency for `frame_end`: high for one cycle, `RESET_CYCLES`+2 edges after the edge that sampled the final falling edge.
- `busy` rises the cycle after the rise is detected in IDLE. It falls together with the `frame_end` pulse, or on `error` entry to SYNC.
- No backpressure: downstream logic must accept `data_valid` every cycle it occurs. The minimum byte spacing is 16 cycles at the defaults.

## Test plan
- **Reset and initial sync.** Release reset with `din` low. Expect `busy`=0 and no pulses. After 600+2 cycles the state is IDLE, and the first subsequent frame is decoded.
- **Nominal frame.** Send bytes 0xA5, 0x3C, 0xFF at 5-cycle/10-cycle highs and a 15-cycle bit period, then a 700-cycle low.
  - Expect three `data_valid` pulses with (`data`, `byte_index`) = (0xA5,0), (0x3C,1), (0xFF,2).
  - Expect one `frame_end`; `error` stays 0.
- **Threshold boundary.** A 6-cycle high decodes as 0; a 7-cycle high decodes as 1. Sending 0x01 encoded with 6-cycle zeros and a 7-cycle last bit yields `data`=0x01.
- **Overlong high.** A 25-cycle high mid-byte gives an `error` pulse and no `data_valid`. Frames that follow the next 600-cycle gap decode correctly again.
- **Partial byte.** Send 12 bits (0x5A, then 4 further bits) followed by a 700-cycle low. Expect one `data_valid` with 0x5A, then `frame_end` and `error` in the same cycle.
- **Reset mid-frame.** Assert `rst`=0 during the 4th bit. Outputs clear immediately. After release with the line still toggling, nothing decodes until a full 600-cycle low gap has been seen.

Source files
------------

// File: rtl/ws2812_input_decoder_if.sv
// Output bundle of the WS2812 receive decoder: decoded bytes and frame events.
// master drives it (the decoder), slave consumes it.
interface ws2812_input_decoder_if;
   logic [7:0] data;
   logic       data_valid;
   logic [7:0] byte_index;
   logic       frame_end;
   logic       error;
   logic       busy;

   modport master (
      output data,
      output data_valid,
      output byte_index,
      output frame_end,
      output error,
      output busy
   );

   modport slave (
      input data,
      input data_valid,
      input byte_index,
      input frame_end,
      input error,
      input busy
   );
endinterface

// File: rtl/ws2812_input_decoder.sv
// WS2812 single-wire receiver: pulse-width bit decode, MSB-first byte assembly
// and reset-gap frame detection.
module ws2812_input_decoder #(
   parameter int THRESHOLD    = 7,
   parameter int MAX_HIGH     = 24,
   parameter int RESET_CYCLES = 600
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   din,
   ws2812_input_decoder_if.master out_if
);

   typedef enum logic [1:0] {
      SYNC,
      IDLE,
      HIGH,
      LOW
   } state_t;

   localparam logic [15:0] THR  = 16'(THRESHOLD);
   localparam logic [15:0] MAXH = 16'(MAX_HIGH);
   localparam logic [15:0] RSTC = 16'(RESET_CYCLES);

   state_t      state_q, state_d;
   logic        s1_q, s2_q, s3_q;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  sh_q, sh_d;
   logic [7:0]  fbc_q, fbc_d;
   logic [7:0]  data_q, data_d;
   logic        dv_q, dv_d;
   logic [7:0]  idx_q, idx_d;
   logic        fe_q, fe_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;

   logic        rise;
   logic        fall;
   logic        bit_val;
   logic [15:0] cnt_inc;
   logic [7:0]  byte_nxt;

   assign rise     = s2_q & ~s3_q;
   assign fall     = ~s2_q & s3_q;
   assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
   assign bit_val  = (cnt_q >= THR);
   assign byte_nxt = {sh_q[6:0], bit_val};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      sh_d      = sh_q;
      fbc_d     = fbc_q;
      data_d    = data_q;
      idx_d     = idx_q;
      dv_d      = 1'b0;
      fe_d      = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         SYNC: begin
            // Only a full low gap proves we are between frames.
            if (s2_q) begin
               cnt_d = '0;
            end else if (cnt_q >= RSTC) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         IDLE: begin
            if (rise) begin
               cnt_d     = 16'd1;
               bit_cnt_d = '0;
               sh_d      = '0;
               fbc_d     = '0;
               state_d   = HIGH;
            end
         end
         HIGH: begin
            if (cnt_q > MAXH) begin
               err_d     = 1'b1;
               sh_d      = '0;
               bit_cnt_d = '0;
               cnt_d     = '0;
               state_d   = SYNC;
            end else if (fall) begin
               sh_d      = byte_nxt;
               bit_cnt_d = bit_cnt_q + 3'd1;
               cnt_d     = 16'd1;
               state_d   = LOW;
               if (bit_cnt_q == 3'd7) begin
                  data_d = byte_nxt;
                  dv_d   = 1'b1;
                  idx_d  = fbc_q;
                  if (fbc_q != 8'hFF) begin
                     fbc_d = fbc_q + 8'd1;
                  end
               end
            end else if (s2_q) begin
               cnt_d = cnt_inc;
            end
         end
         LOW: begin
            if (rise) begin
               cnt_d   = 16'd1;
               state_d = HIGH;
            end else if (cnt_q >= RSTC) begin
               fe_d    = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
               if (bit_cnt_q != 3'd0) begin
                  err_d     = 1'b1;
                  bit_cnt_d = '0;
                  sh_d      = '0;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = SYNC;
         end
      endcase

      busy_d = (state_d == HIGH) || (state_d == LOW);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= SYNC;
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         sh_q      <= '0;
         fbc_q     <= '0;
         data_q    <= '0;
         dv_q      <= 1'b0;
         idx_q     <= '0;
         fe_q      <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         s1_q      <= din;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         sh_q      <= sh_d;
         fbc_q     <= fbc_d;
         data_q    <= data_d;
         dv_q      <= dv_d;
         idx_q     <= idx_d;
         fe_q      <= fe_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   assign out_if.data       = data_q;
   assign out_if.data_valid = dv_q;
   assign out_if.byte_index = idx_q;
   assign out_if.frame_end  = fe_q;
   assign out_if.error      = err_q;
   assign out_if.busy       = busy_q;

endmodule
